// File: rtl/rom_stream_loader_if.sv
// Upstream word stream plus SoC ROM-loader lines, bundled for rom_stream_loader.
// master = the loader itself; slave = the environment (source and SoC side).
interface rom_stream_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  rom_loader_load;
    logic                  rom_loader_sck;
    logic [DATA_WIDTH-1:0] rom_loader_data;
    logic                  rom_loader_ack;

    modport master (
        input  in_valid, in_data, rom_loader_ack,
        output in_ready, rom_loader_load, rom_loader_sck, rom_loader_data
    );

    modport slave (
        output in_valid, in_data, rom_loader_ack,
        input  in_ready, rom_loader_load, rom_loader_sck, rom_loader_data
    );
endinterface

// File: rtl/rom_stream_loader.sv
// Buffers upstream words in a FIFO and replays them to the SoC ROM loader with a 4-phase sck/ack handshake.
// Optional running checksum of acknowledged words: define ROM_LOADER_CHECKSUM_EN.
module rom_stream_loader #(
    parameter int DATA_WIDTH    = 16,
    parameter int WORDS_TO_LOAD = 256,
    parameter int FIFO_DEPTH    = 8,
    parameter int SETUP_CYCLES  = 4,
    parameter int ACK_TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       run,
    rom_stream_loader_if.master        bus,
    output logic                       done_loading,
    output logic                       error,
    output logic [15:0]                words_sent,
    output logic [15:0]                checksum
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = $clog2(SETUP_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [15:0]   WORDS_LAST = 16'(WORDS_TO_LOAD - 1);
    localparam logic [AW:0]   FIFO_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT, S_SCK_HI, S_SCK_LO, S_DONE, S_ERROR
    } state_t;

    state_t r_state, w_state_next;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_count;
    logic [SW-1:0]         r_setup_cnt;
    logic [TW-1:0]         r_tmo;
    logic [15:0]           r_words_sent;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_load, r_sck, r_done, r_error;

    logic w_full, w_empty, w_in_ready, w_push, w_pop, w_flush;
    logic w_start, w_word_done, w_tmo_hit;
    logic w_load_next, w_sck_next, w_done_next, w_error_next;

    // in_ready depends only on registered occupancy and state, never on in_valid
    assign w_full     = (r_count == FIFO_FULL);
    assign w_empty    = (r_count == '0);
    assign w_in_ready = !w_full && (r_state != S_ERROR);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_tmo_hit  = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_sck   <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_load  <= w_load_next;
            r_sck   <= w_sck_next;
            r_done  <= w_done_next;
            r_error <= w_error_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_start      = 1'b0;
        w_word_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_SETUP;
                    w_start      = 1'b1;
                end
            end
            S_SETUP: begin
                if (r_setup_cnt == SETUP_LAST) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SCK_HI;
                end
            end
            S_SCK_HI: begin
                if (bus.rom_loader_ack) w_state_next = S_SCK_LO;
                else if (w_tmo_hit)     w_state_next = S_ERROR;
            end
            S_SCK_LO: begin
                if (!bus.rom_loader_ack) begin
                    w_word_done  = 1'b1;
                    w_state_next = (r_words_sent == WORDS_LAST) ? S_DONE : S_WAIT;
                end else if (w_tmo_hit) begin
                    w_state_next = S_ERROR;
                end
            end
            S_DONE: begin
                if (!run) begin
                    w_state_next = S_IDLE;
                    w_flush      = 1'b1;
                end
            end
            S_ERROR: w_state_next = S_ERROR;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave flops directly
    always_comb begin
        w_load_next  = 1'b0;
        w_sck_next   = 1'b0;
        w_done_next  = 1'b0;
        w_error_next = 1'b0;
        case (w_state_next)
            S_SETUP, S_WAIT, S_SCK_LO: w_load_next = 1'b1;
            S_SCK_HI: begin
                w_load_next = 1'b1;
                w_sck_next  = 1'b1;
            end
            S_DONE:  w_done_next  = 1'b1;
            S_ERROR: w_error_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_setup_cnt  <= '0;
            r_tmo        <= '0;
            r_words_sent <= '0;
            r_data       <= '0;
        end else begin
            if (w_start)                    r_setup_cnt <= '0;
            else if (r_state == S_SETUP)    r_setup_cnt <= r_setup_cnt + SW'(1);

            // any state change restarts the ack wait window
            if (w_state_next != r_state)    r_tmo <= '0;
            else if (r_state == S_SCK_HI || r_state == S_SCK_LO)
                                            r_tmo <= r_tmo + TW'(1);

            if (w_start)                    r_words_sent <= '0;
            else if (w_word_done)           r_words_sent <= r_words_sent + 16'd1;

            if (w_pop)                      r_data <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          r_checksum <= '0;
        else if (w_start)      r_checksum <= '0;
        else if (w_word_done)  r_checksum <= r_checksum + 16'(r_data);
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign bus.in_ready        = w_in_ready;
    assign bus.rom_loader_load = r_load;
    assign bus.rom_loader_sck  = r_sck;
    assign bus.rom_loader_data = r_data;
    assign done_loading        = r_done;
    assign error               = r_error;
    assign words_sent          = r_words_sent;
endmodule
